csr_regfile: RTL and testbench

CSR_REGFILE -- requirements
Module: csr_regfile

---
 rtl/csr_pkg.sv | 48 ++++
 rtl/csr_timer.sv | 66 ++++++
 rtl/csr_regfile.sv | 184 ++++++++++++++++++
 tb/tb_csr_regfile.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR numbers, field positions, ecodes and write-merge helper
package csr_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam int CRMD_PLV_LO     = 0;
    localparam int CRMD_PLV_HI     = 1;
    localparam int CRMD_IE         = 2;
    localparam int CRMD_DA         = 3;
    localparam int PRMD_PPLV_LO    = 0;
    localparam int PRMD_PPLV_HI    = 1;
    localparam int PRMD_PIE        = 2;
    localparam int ECFG_LIE_HI     = 12;
    localparam int ESTAT_IS_SW_HI  = 1;
    localparam int ESTAT_TI        = 11;
    localparam int EENTRY_VA_LO    = 6;
    localparam int TCFG_EN         = 0;
    localparam int TCFG_PERIODIC   = 1;
    localparam int TCFG_INITVAL_LO = 2;

    localparam logic [31:0] CRMD_RESET = 32'h0000_0008;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    // Masked read-modify-write: only bits set in mask take the new value.
    function automatic logic [31:0] wmerge(input logic [31:0] old,
                                           input logic [31:0] mask,
                                           input logic [31:0] value);
        return (old & ~mask) | (value & mask);
    endfunction

endpackage

// File: rtl/csr_timer.sv
// rtl/csr_timer.sv - constant timer (TID/TCFG/TVAL/TICLR), built only with CSR_TIMER_EN
module csr_timer
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        we,
    input  logic [13:0] wr_num,
    input  logic [31:0] wr_mask,
    input  logic [31:0] wr_value,
    output logic [31:0] tid,
    output logic [31:0] tcfg,
    output logic [31:0] tval,
    output logic        ti
);

    logic [31:0] tcfg_new;
    logic        tcfg_wr;
    logic        load;
    logic        ti_set;
    logic        ti_clr;

    assign tcfg_new = wmerge(tcfg, wr_mask, wr_value);
    assign tcfg_wr  = we && (wr_num == CSR_TCFG);
    assign load     = tcfg_wr && tcfg_new[TCFG_EN];
    assign ti_set   = !load && tcfg[TCFG_EN] && (tval == 32'd1);
    assign ti_clr   = we && (wr_num == CSR_TICLR) && wr_value[0] && wr_mask[0];

    // TID and TCFG are plain software registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tid  <= '0;
            tcfg <= '0;
        end else begin
            if (we && (wr_num == CSR_TID))
                tid <= wmerge(tid, wr_mask, wr_value);
            if (tcfg_wr)
                tcfg <= tcfg_new;
        end
    end

    // Countdown: load on enabling write, decrement to 0, reload only when periodic.
    always_ff @(posedge clk) begin
        if (!resetn)
            tval <= '0;
        else if (load)
            tval <= {tcfg_new[31:TCFG_INITVAL_LO], 2'b00};
        else if (tcfg[TCFG_EN]) begin
            if (tval != 32'd0)
                tval <= tval - 32'd1;
            else if (tcfg[TCFG_PERIODIC])
                tval <= {tcfg[31:TCFG_INITVAL_LO], 2'b00};
        end
    end

    // Timer interrupt latch; a set on the same edge as a clear wins.
    always_ff @(posedge clk) begin
        if (!resetn)
            ti <= 1'b0;
        else if (ti_set)
            ti <= 1'b1;
        else if (ti_clr)
            ti <= 1'b0;
    end

endmodule

// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - exception CSR file; timer CSRs present when CSR_TIMER_EN is defined
module csr_regfile
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic [13:0] csr_rd_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [13:0] csr_wr_num,
    input  logic [31:0] csr_wr_mask,
    input  logic [31:0] csr_wr_value,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic        ertn_flush,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_pc,
    output logic        has_int
);

    logic [1:0]  crmd_plv;
    logic        crmd_ie;
    logic        crmd_da;
    logic [1:0]  prmd_pplv;
    logic        prmd_pie;
    logic [12:0] ecfg_lie;
    logic [1:0]  estat_is_sw;
    logic [5:0]  estat_ecode;
    logic [8:0]  estat_esubcode;
    logic [31:0] era;
    logic [25:0] eentry_va;
    logic [31:0] save_r [0:3];

    logic [12:0] estat_is;
    logic [31:0] crmd_w, prmd_w, ecfg_w, estat_w, eentry_w;
    logic [31:0] wr_old, wm, rd_word;
    logic        sw_we;
    logic        ti;

    // An exception commit swallows any software write in the same cycle.
    assign sw_we = csr_we && !wb_ex;

`ifdef CSR_TIMER_EN
    logic [31:0] tid, tcfg, tval;

    csr_timer u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .we       (sw_we),
        .wr_num   (csr_wr_num),
        .wr_mask  (csr_wr_mask),
        .wr_value (csr_wr_value),
        .tid      (tid),
        .tcfg     (tcfg),
        .tval     (tval),
        .ti       (ti)
    );
`else
    assign ti = 1'b0;
`endif

    // Interrupt status: software bits, timer bit, other hardware lines absent.
    always_comb begin
        estat_is = '0;
        estat_is[ESTAT_IS_SW_HI:0] = estat_is_sw;
        estat_is[ESTAT_TI] = ti;
    end

    assign crmd_w   = {28'b0, crmd_da, crmd_ie, crmd_plv};
    assign prmd_w   = {29'b0, prmd_pie, prmd_pplv};
    assign ecfg_w   = {19'b0, ecfg_lie};
    assign estat_w  = {1'b0, estat_esubcode, estat_ecode, 3'b0, estat_is};
    assign eentry_w = {eentry_va, 6'b0};

    // Old value of the write target, merged with the masked write data.
    always_comb begin
        wr_old = '0;
        case (csr_wr_num)
            CSR_CRMD:   wr_old = crmd_w;
            CSR_PRMD:   wr_old = prmd_w;
            CSR_ECFG:   wr_old = ecfg_w;
            CSR_ESTAT:  wr_old = estat_w;
            CSR_ERA:    wr_old = era;
            CSR_EENTRY: wr_old = eentry_w;
            CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3: wr_old = save_r[csr_wr_num[1:0]];
            default:    wr_old = '0;
        endcase
    end
    assign wm = wmerge(wr_old, csr_wr_mask, csr_wr_value);

    // CRMD: exception > ertn > software, per field (DA is software-only).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            crmd_plv <= 2'd0;
            crmd_ie  <= 1'b0;
            crmd_da  <= 1'b1;
        end else if (wb_ex) begin
            crmd_plv <= 2'd0;
            crmd_ie  <= 1'b0;
        end else begin
            if (ertn_flush) begin
                crmd_plv <= prmd_pplv;
                crmd_ie  <= prmd_pie;
            end else if (sw_we && csr_wr_num == CSR_CRMD) begin
                crmd_plv <= wm[CRMD_PLV_HI:CRMD_PLV_LO];
                crmd_ie  <= wm[CRMD_IE];
            end
            if (sw_we && csr_wr_num == CSR_CRMD)
                crmd_da <= wm[CRMD_DA];
        end
    end

    // PRMD, ESTAT and ERA capture exception context; otherwise software-written.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prmd_pplv      <= 2'd0;
            prmd_pie       <= 1'b0;
            estat_is_sw    <= 2'd0;
            estat_ecode    <= 6'd0;
            estat_esubcode <= 9'd0;
            era            <= '0;
        end else if (wb_ex) begin
            prmd_pplv      <= crmd_plv;
            prmd_pie       <= crmd_ie;
            estat_ecode    <= wb_ecode;
            estat_esubcode <= wb_esubcode;
            era            <= wb_pc;
        end else if (sw_we) begin
            if (csr_wr_num == CSR_PRMD) begin
                prmd_pplv <= wm[PRMD_PPLV_HI:PRMD_PPLV_LO];
                prmd_pie  <= wm[PRMD_PIE];
            end
            if (csr_wr_num == CSR_ESTAT)
                estat_is_sw <= wm[ESTAT_IS_SW_HI:0];
            if (csr_wr_num == CSR_ERA)
                era <= wm;
        end
    end

    // Software-only registers: ECFG, EENTRY, SAVE0-3.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ecfg_lie  <= '0;
            eentry_va <= '0;
            for (int i = 0; i < 4; i++) save_r[i] <= '0;
        end else if (sw_we) begin
            if (csr_wr_num == CSR_ECFG)
                ecfg_lie <= wm[ECFG_LIE_HI:0];
            if (csr_wr_num == CSR_EENTRY)
                eentry_va <= wm[31:EENTRY_VA_LO];
            if (csr_wr_num[13:2] == CSR_SAVE0[13:2])
                save_r[csr_wr_num[1:0]] <= wm;
        end
    end

    // Combinational read mux; unimplemented numbers and TICLR read zero.
    always_comb begin
        rd_word = '0;
        case (csr_rd_num)
            CSR_CRMD:   rd_word = crmd_w;
            CSR_PRMD:   rd_word = prmd_w;
            CSR_ECFG:   rd_word = ecfg_w;
            CSR_ESTAT:  rd_word = estat_w;
            CSR_ERA:    rd_word = era;
            CSR_EENTRY: rd_word = eentry_w;
            CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3: rd_word = save_r[csr_rd_num[1:0]];
`ifdef CSR_TIMER_EN
            CSR_TID:    rd_word = tid;
            CSR_TCFG:   rd_word = tcfg;
            CSR_TVAL:   rd_word = tval;
`endif
            default:    rd_word = '0;
        endcase
    end

    // While reset is held, outputs present the reset state regardless of register contents.
    assign csr_rvalue = resetn ? rd_word : ((csr_rd_num == CSR_CRMD) ? CRMD_RESET : 32'd0);
    assign ex_entry   = resetn ? eentry_w : 32'd0;
    assign ertn_pc    = resetn ? era : 32'd0;
    assign has_int    = resetn && crmd_ie && (|(estat_is & ecfg_lie));

endmodule

// File: tb/tb_csr_regfile.sv
// tb/tb_csr_regfile.sv - directed table and sequence checks for csr_regfile
module tb_csr_regfile;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [13:0] csr_rd_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [13:0] csr_wr_num;
    logic [31:0] csr_wr_mask;
    logic [31:0] csr_wr_value;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic        ertn_flush;
    logic [31:0] ex_entry;
    logic [31:0] ertn_pc;
    logic        has_int;

    int n_cmp = 0;
    int n_err = 0;

    csr_regfile dut (
        .clk          (clk),
        .resetn       (resetn),
        .csr_rd_num   (csr_rd_num),
        .csr_rvalue   (csr_rvalue),
        .csr_we       (csr_we),
        .csr_wr_num   (csr_wr_num),
        .csr_wr_mask  (csr_wr_mask),
        .csr_wr_value (csr_wr_value),
        .wb_ex        (wb_ex),
        .wb_ecode     (wb_ecode),
        .wb_esubcode  (wb_esubcode),
        .wb_pc        (wb_pc),
        .ertn_flush   (ertn_flush),
        .ex_entry     (ex_entry),
        .ertn_pc      (ertn_pc),
        .has_int      (has_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] num;
        logic [31:0] mask;
        logic [31:0] value;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

`ifdef CSR_TIMER_EN
    localparam logic [31:0] TID_EXP = 32'h0000_0055;
`else
    localparam logic [31:0] TID_EXP = 32'h0000_0000;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic rd_check(input string name, input logic [13:0] num, input logic [31:0] exp);
        csr_rd_num = num;
        #1;
        check(name, csr_rvalue, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] value);
        csr_we = 1'b1;
        csr_wr_num = num;
        csr_wr_mask = mask;
        csr_wr_value = value;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        csr_rd_num = CSR_CRMD;
        csr_we = 1'b0;
        csr_wr_num = '0;
        csr_wr_mask = '0;
        csr_wr_value = '0;
        wb_ex = 1'b0;
        wb_ecode = '0;
        wb_esubcode = '0;
        wb_pc = '0;
        ertn_flush = 1'b0;

        vecs[0]  = '{CSR_EENTRY, 32'hFFFF_FFFF, 32'h1C00_8000, 32'h1C00_8000};
        vecs[1]  = '{CSR_EENTRY, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h1C00_FFC0};
        vecs[2]  = '{CSR_SAVE0,  32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[3]  = '{CSR_SAVE3,  32'hFF00_FF00, 32'h1234_5678, 32'h1200_5600};
        vecs[4]  = '{CSR_ECFG,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1FFF};
        vecs[5]  = '{CSR_ESTAT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
        vecs[6]  = '{CSR_PRMD,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007};
        vecs[7]  = '{CSR_ERA,    32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vecs[8]  = '{CSR_CRMD,   32'h0000_000F, 32'h0000_0006, 32'h0000_0006};
        vecs[9]  = '{14'h007,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[10] = '{CSR_TID,    32'hFFFF_FFFF, 32'h0000_0055, TID_EXP};
        vecs[11] = '{CSR_TICLR,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[12] = '{CSR_TVAL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};

        // Outputs while reset is held, before and after the first edge.
        #1;
        rd_check("rst_crmd_pre", CSR_CRMD, 32'h8);
        check("rst_has_int_pre", {31'b0, has_int}, 32'h0);
        check("rst_ex_entry_pre", ex_entry, 32'h0);
        check("rst_ertn_pc_pre", ertn_pc, 32'h0);
        tick();
        tick();
        resetn = 1'b1;
        rd_check("rst_crmd", CSR_CRMD, 32'h8);
        rd_check("rst_estat", CSR_ESTAT, 32'h0);
        rd_check("rst_eentry", CSR_EENTRY, 32'h0);
        check("rst_has_int", {31'b0, has_int}, 32'h0);

        // Masked writes and readback.
        for (int i = 0; i < 13; i++) begin
            csr_write(vecs[i].num, vecs[i].mask, vecs[i].value);
            rd_check($sformatf("vec%0d_rd", i), vecs[i].num, vecs[i].exp);
            if (vecs[i].num == CSR_EENTRY)
                check($sformatf("vec%0d_ex_entry", i), ex_entry, vecs[i].exp);
        end
        rd_check("save0_kept", CSR_SAVE0, 32'hDEAD_BEEF);
        check("tbl_ertn_pc", ertn_pc, 32'hA5A5_A5A5);
        check("tbl_has_int", {31'b0, has_int}, 32'h1);

        // Exception entry.
        do_reset();
        csr_write(CSR_CRMD, 32'hFFFF_FFFF, 32'h7);
        rd_check("pre_ex_crmd", CSR_CRMD, 32'h7);
        wb_ex = 1'b1; wb_pc = 32'h1C00_0100; wb_ecode = ECODE_SYS; wb_esubcode = 9'h001;
        tick();
        wb_ex = 1'b0;
        rd_check("ex_crmd", CSR_CRMD, 32'h0);
        rd_check("ex_prmd", CSR_PRMD, 32'h7);
        rd_check("ex_era", CSR_ERA, 32'h1C00_0100);
        rd_check("ex_estat", CSR_ESTAT, 32'h004B_0000);
        check("ex_ertn_pc", ertn_pc, 32'h1C00_0100);

        // Exception return.
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        rd_check("ertn_crmd", CSR_CRMD, 32'h7);
        check("ertn_pc", ertn_pc, 32'h1C00_0100);

        // Exception, return and CRMD write in one cycle: only the exception lands.
        wb_ex = 1'b1; wb_pc = 32'h1C00_0200; wb_ecode = ECODE_BRK; wb_esubcode = 9'h000;
        ertn_flush = 1'b1;
        csr_write(CSR_CRMD, 32'hFFFF_FFFF, 32'h8);
        wb_ex = 1'b0; ertn_flush = 1'b0;
        rd_check("conf_crmd", CSR_CRMD, 32'h0);
        rd_check("conf_prmd", CSR_PRMD, 32'h7);
        rd_check("conf_era", CSR_ERA, 32'h1C00_0200);

        // Return beats a CRMD write on PLV/IE, DA still taken from the write.
        ertn_flush = 1'b1;
        csr_write(CSR_CRMD, 32'h0000_000F, 32'h8);
        ertn_flush = 1'b0;
        rd_check("ertn_we_crmd", CSR_CRMD, 32'hF);

        // Any write is dropped under an exception.
        wb_ex = 1'b1;
        csr_write(CSR_SAVE1, 32'hFFFF_FFFF, 32'h1234);
        wb_ex = 1'b0;
        rd_check("ex_drop_save1", CSR_SAVE1, 32'h0);

`ifdef CSR_TIMER_EN
        // Periodic countdown and timer interrupt.
        do_reset();
        csr_write(CSR_CRMD, 32'hF, 32'h4);
        csr_write(CSR_ECFG, 32'hFFFF_FFFF, 32'h800);
        csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h13);
        rd_check("tval_load", CSR_TVAL, 32'd16);
        for (int k = 15; k >= 0; k--) begin
            tick();
            rd_check($sformatf("tval_%0d", k), CSR_TVAL, k);
            rd_check($sformatf("ti_at_%0d", k), CSR_ESTAT, (k == 0) ? 32'h800 : 32'h0);
            check($sformatf("has_int_at_%0d", k), {31'b0, has_int}, (k == 0) ? 32'h1 : 32'h0);
        end
        tick();
        rd_check("tval_reload", CSR_TVAL, 32'd16);
        csr_write(CSR_TICLR, 32'hFFFF_FFFF, 32'h1);
        rd_check("ticlr_is", CSR_ESTAT, 32'h0);
        check("ticlr_has_int", {31'b0, has_int}, 32'h0);
        rd_check("tval_after_clr", CSR_TVAL, 32'd15);
`else
        csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h13);
        tick();
        rd_check("notimer_tcfg", CSR_TCFG, 32'h0);
        rd_check("notimer_tval", CSR_TVAL, 32'h0);
`endif

        // Reset in the middle of a countdown.
        do_reset();
        csr_write(CSR_EENTRY, 32'hFFFF_FFFF, 32'h1C00_8000);
        csr_write(CSR_ERA, 32'hFFFF_FFFF, 32'h1234);
        csr_write(CSR_ESTAT, 32'hFFFF_FFFF, 32'h3);
        csr_write(CSR_ECFG, 32'hFFFF_FFFF, 32'h3);
        csr_write(CSR_CRMD, 32'hF, 32'h4);
        csr_write(CSR_TCFG, 32'hFFFF_FFFF, 32'h13);
        tick(); tick(); tick();
        check("mid_has_int", {31'b0, has_int}, 32'h1);
        resetn = 1'b0;
        #1;
        check("mid_rst_has_int", {31'b0, has_int}, 32'h0);
        check("mid_rst_ex_entry", ex_entry, 32'h0);
        check("mid_rst_ertn_pc", ertn_pc, 32'h0);
        rd_check("mid_rst_crmd", CSR_CRMD, 32'h8);
        tick();
        rd_check("mid_rst_tval", CSR_TVAL, 32'h0);
        resetn = 1'b1;
        tick();
        tick();
        rd_check("post_rst_tval", CSR_TVAL, 32'h0);
        rd_check("post_rst_tcfg", CSR_TCFG, 32'h0);
        rd_check("post_rst_crmd", CSR_CRMD, 32'h8);
        rd_check("post_rst_eentry", CSR_EENTRY, 32'h0);
        check("post_rst_has_int", {31'b0, has_int}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
